// File: rtl/ctrl_pkg.sv
// ctrl_pkg: control-word layout, pipeline stage record and forward-select
// encodings shared by the decoder, ctrl_pipe and ctrl_hazard.
// No ports; the optional CTRL_PIPE_FORWARDING_EN build uses the FWD_* selects.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 11;
  typedef logic [CTRL_W-1:0] ctrl_t;

  // Bit positions inside the control word
  localparam int unsigned CTRL_JUMP       = 10;
  localparam int unsigned CTRL_BRANCH     = 9;
  localparam int unsigned CTRL_MEM_READ   = 8;
  localparam int unsigned CTRL_MEM_WRITE  = 7;
  localparam int unsigned CTRL_MEM_TO_REG = 6;
  localparam int unsigned CTRL_ALU_OP_HI  = 5;
  localparam int unsigned CTRL_ALU_OP_LO  = 4;
  localparam int unsigned CTRL_EXCEPTION  = 3;
  localparam int unsigned CTRL_ALU_SRC    = 2;
  localparam int unsigned CTRL_REG_WRITE  = 1;
  localparam int unsigned CTRL_REG_DST    = 0;

  // Operand source selects
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  typedef struct packed {
    logic       valid;
    ctrl_t      ctrl;
    logic [4:0] dest;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // A producer matches a source register only if it really writes a
  // register other than r0.
  function automatic logic dest_hit(input logic       valid,
                                    input logic       writes,
                                    input logic [4:0] dest,
                                    input logic [4:0] src);
    return valid && writes && (dest != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/ctrl_hazard.sv
// ctrl_hazard: purely combinational hazard, stall, flush and forward logic.
// Ports: ID operand info, EX/MEM (and WB when CTRL_PIPE_FORWARDING_EN is
// defined) stage fields, ex_redirect, reset; outputs stall, flush_id,
// exc_pulse and, with CTRL_PIPE_FORWARDING_EN, fwd_a/fwd_b.
// Priority: exception > redirect > stall; reset forces every output to 0.
module ctrl_hazard
  import ctrl_pkg::*;
(
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_redirect,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
`ifndef CTRL_PIPE_FORWARDING_EN
  input  logic       ex_reg_write,
`endif
  input  logic [4:0] ex_dest,
  input  logic       mem_valid,
  input  logic       mem_reg_write,
  input  logic       mem_exc,
  input  logic [4:0] mem_dest,
`ifdef CTRL_PIPE_FORWARDING_EN
  input  logic       wb_valid,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_dest,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b,
`endif
  output logic       stall,
  output logic       flush_id,
  output logic       exc_pulse
);

  logic exc;
  logic redirect;
  logic load_use;
  logic hazard;

  assign exc      = mem_valid && mem_exc;
  assign redirect = ex_redirect && ex_valid && !exc;

  // Load-use ignores reg_write: a load always owns its destination.
  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_dest != 5'd0) &&
                    ((ex_dest == id_rs) || (ex_dest == id_rt));

`ifdef CTRL_PIPE_FORWARDING_EN
  function automatic fwd_sel_t pick(input logic [4:0] src);
    if (dest_hit(mem_valid, mem_reg_write, mem_dest, src)) return FWD_MEM;
    if (dest_hit(wb_valid, wb_reg_write, wb_dest, src))    return FWD_WB;
    return FWD_RF;
  endfunction

  assign hazard = load_use;
  assign fwd_a  = reset ? FWD_RF : pick(id_rs);
  assign fwd_b  = reset ? FWD_RF : pick(id_rt);
`else
  // WB is left out: the register file writes before it is read.
  logic raw;
  assign raw = id_valid &&
               (dest_hit(ex_valid, ex_reg_write, ex_dest, id_rs)   ||
                dest_hit(ex_valid, ex_reg_write, ex_dest, id_rt)   ||
                dest_hit(mem_valid, mem_reg_write, mem_dest, id_rs) ||
                dest_hit(mem_valid, mem_reg_write, mem_dest, id_rt));
  assign hazard = load_use || raw;
`endif

  assign exc_pulse = !reset && exc;
  assign flush_id  = !reset && (exc || redirect);
  assign stall     = !reset && hazard && !exc && !redirect;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID->EX->MEM->WB control pipeline registers.
// Ports: clk, reset (sync, active high), id_ctrl/id_valid/id_rs/id_rt/id_dest
// from decode, ex_redirect from EX; outputs ex_/mem_/wb_ ctrl, valid, dest,
// stall, flush_id, exc_pulse, and fwd_a/fwd_b when CTRL_PIPE_FORWARDING_EN
// is defined (otherwise every RAW hazard on EX/MEM stalls).
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_dest,
  input  logic              ex_redirect,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_valid,
  output logic [4:0]        ex_dest,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic              mem_valid,
  output logic [4:0]        mem_dest,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic              wb_valid,
  output logic [4:0]        wb_dest,
`ifdef CTRL_PIPE_FORWARDING_EN
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
`endif
  output logic              stall,
  output logic              flush_id,
  output logic              exc_pulse
);

  stage_t ex_q, mem_q, wb_q, ex_d;

  ctrl_hazard u_hazard (
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_redirect   (ex_redirect),
    .ex_valid      (ex_q.valid),
    .ex_mem_read   (ex_q.ctrl[CTRL_MEM_READ]),
`ifndef CTRL_PIPE_FORWARDING_EN
    .ex_reg_write  (ex_q.ctrl[CTRL_REG_WRITE]),
`endif
    .ex_dest       (ex_q.dest),
    .mem_valid     (mem_q.valid),
    .mem_reg_write (mem_q.ctrl[CTRL_REG_WRITE]),
    .mem_exc       (mem_q.ctrl[CTRL_EXCEPTION]),
    .mem_dest      (mem_q.dest),
`ifdef CTRL_PIPE_FORWARDING_EN
    .wb_valid      (wb_q.valid),
    .wb_reg_write  (wb_q.ctrl[CTRL_REG_WRITE]),
    .wb_dest       (wb_q.dest),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
`endif
    .stall         (stall),
    .flush_id      (flush_id),
    .exc_pulse     (exc_pulse)
  );

  // flush_id covers both exception and redirect kills of the ID slot.
  always_comb begin
    ex_d = BUBBLE;
    if (id_valid && !stall && !flush_id) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = id_ctrl;
      ex_d.dest  = id_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= exc_pulse ? BUBBLE : ex_q;
      wb_q  <= exc_pulse ? BUBBLE : mem_q;
    end
  end

  assign ex_ctrl   = ex_q.ctrl;
  assign ex_valid  = ex_q.valid;
  assign ex_dest   = ex_q.dest;
  assign mem_ctrl  = mem_q.ctrl;
  assign mem_valid = mem_q.valid;
  assign mem_dest  = mem_q.dest;
  assign wb_ctrl   = wb_q.ctrl;
  assign wb_valid  = wb_q.valid;
  assign wb_dest   = wb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: scoreboard bench for ctrl_pipe. Instructions expected to
// retire are queued when driven and compared as they appear in WB.
// Honours CTRL_PIPE_FORWARDING_EN to select the forwarding or stall scenario.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] id_ctrl;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        ex_redirect;
  logic [10:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic        ex_valid, mem_valid, wb_valid;
  logic [4:0]  ex_dest, mem_dest, wb_dest;
  logic        stall, flush_id, exc_pulse;
`ifdef CTRL_PIPE_FORWARDING_EN
  logic [1:0]  fwd_a, fwd_b;
`endif

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .reset(reset),
    .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .ex_redirect(ex_redirect),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .ex_dest(ex_dest),
    .mem_ctrl(mem_ctrl), .mem_valid(mem_valid), .mem_dest(mem_dest),
    .wb_ctrl(wb_ctrl), .wb_valid(wb_valid), .wb_dest(wb_dest),
`ifdef CTRL_PIPE_FORWARDING_EN
    .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
    .stall(stall), .flush_id(flush_id), .exc_pulse(exc_pulse)
  );

  typedef struct {
    logic [10:0] ctrl;
    logic [4:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // WB monitor: every valid retirement must match the oldest queued entry,
  // and a bubble must carry zero ctrl/dest.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("wb_unexpected", {16'd0, wb_ctrl, wb_dest}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wb_ctrl", {21'd0, wb_ctrl}, {21'd0, e.ctrl});
          check("wb_dest", {27'd0, wb_dest}, {27'd0, e.dest});
        end
      end else begin
        check("wb_bubble", {16'd0, wb_ctrl, wb_dest}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [10:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] d, input logic push);
    id_valid = v;
    id_ctrl  = c;
    id_rs    = rs;
    id_rt    = rt;
    id_dest  = d;
    if (push) sb.push_back('{ctrl: c, dest: d});
    #1;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 11'($urandom), 5'd0, 5'd0, 5'($urandom), 1'b0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] c;
    reset = 1'b1;
    ex_redirect = 1'b0;
    drive(1'b1, 11'h165, 5'd8, 5'd8, 5'd8, 1'b0);
    tick();
    mon_en = 1'b1;
    check("rst_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd0);
    check("rst_ctrl_dest", {ex_ctrl, ex_dest, mem_ctrl, mem_dest} , 32'd0);
    check("rst_comb", {29'd0, stall, flush_id, exc_pulse}, 32'd0);
    tick();
    reset = 1'b0;

    // Independent traffic: r0 sources never hazard; id_valid=0 is a bubble.
    for (int i = 0; i < 8; i++) begin
      c = 11'($urandom) & 11'h7F7;
      if (i % 3 == 2) drive(1'b0, c, 5'd0, 5'd0, 5'($urandom_range(1, 31)), 1'b0);
      else            drive(1'b1, c, 5'd0, 5'd0, 5'($urandom_range(1, 31)), 1'b1);
      check("stream_stall", {31'd0, stall}, 32'd0);
      tick();
    end
    bubbles(3);

    // Load-use: one stall cycle, EX bubble, then dependent enters EX.
    drive(1'b1, 11'h165, 5'd0, 5'd0, 5'd8, 1'b1);
    tick();
    drive(1'b1, 11'h023, 5'd8, 5'd0, 5'd9, 1'b0);
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_flush", {31'd0, flush_id}, 32'd0);
    tick();
    check("lu_ex_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_stall_clear", {31'd0, stall}, 32'd0);
    sb.push_back('{ctrl: 11'h023, dest: 5'd9});
    tick();
    check("lu_ex_dep", {15'd0, ex_valid, ex_ctrl, ex_dest}, {15'd0, 1'b1, 11'h023, 5'd9});
    bubbles(3);

`ifdef CTRL_PIPE_FORWARDING_EN
    // MEM beats WB; MEM dest=0 never matches.
    drive(1'b1, 11'h023, 5'd0, 5'd0, 5'd5, 1'b1); tick();
    drive(1'b1, 11'h022, 5'd0, 5'd0, 5'd5, 1'b1); tick();
    drive(1'b1, 11'h023, 5'd0, 5'd0, 5'd0, 1'b1); tick();
    drive(1'b1, 11'h023, 5'd5, 5'd5, 5'd6, 1'b0);
    check("fwd_a_mem", {30'd0, fwd_a}, 32'd1);
    check("fwd_b_mem", {30'd0, fwd_b}, 32'd1);
    check("fwd_stall", {31'd0, stall}, 32'd0);
    drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 11'h023, 5'd5, 5'd1, 5'd6, 1'b0);
    check("fwd_a_wb", {30'd0, fwd_a}, 32'd2);
    check("fwd_b_rf", {30'd0, fwd_b}, 32'd0);
    drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0);
`else
    // RAW on MEM stalls without forwarding; r0 never matches.
    drive(1'b1, 11'h023, 5'd0, 5'd0, 5'd3, 1'b1); tick();
    drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0); tick();
    drive(1'b1, 11'h023, 5'd0, 5'd3, 5'd4, 1'b0);
    check("raw_mem_stall", {31'd0, stall}, 32'd1);
    drive(1'b1, 11'h023, 5'd0, 5'd0, 5'd4, 1'b1);
    check("raw_r0_nostall", {31'd0, stall}, 32'd0);
    tick();
    // Same producer now in WB: excluded from the check.
    drive(1'b1, 11'h023, 5'd3, 5'd0, 5'd0, 1'b0);
    check("raw_wb_nostall", {31'd0, stall}, 32'd0);
    drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0);
`endif
    bubbles(3);

    // Redirect without ex_valid does nothing.
    ex_redirect = 1'b1;
    drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    check("redir_novalid", {30'd0, flush_id, stall}, 32'd0);
    ex_redirect = 1'b0;

    // Redirect beats load-use stall.
    drive(1'b1, 11'h165, 5'd0, 5'd0, 5'd8, 1'b1);
    tick();
    ex_redirect = 1'b1;
    drive(1'b1, 11'h023, 5'd8, 5'd0, 5'd9, 1'b0);
    check("redir_stall", {31'd0, stall}, 32'd0);
    check("redir_flush", {31'd0, flush_id}, 32'd1);
    tick();
    ex_redirect = 1'b0;
    drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    check("redir_ex_bubble", {31'd0, ex_valid}, 32'd0);
    bubbles(3);

    // Exception in MEM kills EX, MEM and WB.
    drive(1'b1, 11'h00A, 5'd0, 5'd0, 5'd7, 1'b0); tick();
    drive(1'b1, 11'h023, 5'd0, 5'd0, 5'd10, 1'b0); tick();
    drive(1'b1, 11'h023, 5'd0, 5'd0, 5'd11, 1'b0);
    check("exc_pulse", {29'd0, exc_pulse, flush_id, stall}, 32'd6);
    tick();
    drive(1'b0, 11'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    check("exc_kill", {28'd0, ex_valid, mem_valid, wb_valid, exc_pulse}, 32'd0);
    bubbles(3);

    // Reset overrides an exception sitting in MEM.
    drive(1'b1, 11'h008, 5'd0, 5'd0, 5'd12, 1'b0); tick();
    drive(1'b1, 11'h023, 5'd0, 5'd0, 5'd13, 1'b0); tick();
    reset = 1'b1;
    #1;
    check("rst_exc_comb", {29'd0, exc_pulse, flush_id, stall}, 32'd0);
    tick();
    check("rst_mid_valids", {29'd0, ex_valid, mem_valid, wb_valid}, 32'd0);
    check("rst_mid_fields", {mem_ctrl, mem_dest, wb_ctrl, wb_dest}, 32'd0);
    check("rst_mid_exc", {31'd0, exc_pulse}, 32'd0);
    reset = 1'b0;
    bubbles(4);

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
